l2_pool_ctrl: RTL
=================

// Module: l2_pool_ctrl
// PURPOSE
// - Sequencer for the layer-2 feature-map RAM (11x11 map, 18-bit signed words; 2x2-window read port).
// - Accepts one frame of 121 pixels from the layer-2 conv stage and writes it row-major at addr 0..120.
// - Then walks the 25 stride-2 2x2 pooling windows and reduces each window to its signed max.
// - Emits the 5x5 pooled stream to the next layer; row 10 and column 10 are dropped (floor pooling).
// PARAMETERS
// - DIM   11  feature-map side; frame = DIM*DIM words
// - AW    7   RAM address width
// - DW    18  data width, two's complement
// PORTS
// - clk          in   1      clock; single clock domain
// - rst          in   1      reset, synchronous, active-high
// - in_vld       in   1      conv pixel valid
// - in_data      in   DW     conv pixel
// - in_rdy       out  1      controller accepts pixel (FILL state only)
// - ram_wr       out  1      RAM write enable
// - ram_addr_wr  out  AW     RAM write address
// - ram_din      out  DW     RAM write data
// - ram_rd       out  1      RAM read enable
// - ram_addr_rd  out  AW     window anchor = bottom-right word; RAM returns anchor-12, -11, -1, anchor
// - ram_dout     in   4xDW   window words [0]=TL [1]=TR [2]=BL [3]=BR; combinational from ram_addr_rd
// - pool_vld     out  1      pooled result valid
// - pool_data    out  DW     pooled result (signed max of 4)
// - pool_rdy     in   1      downstream accepts pooled result
// - frame_done   out  1      one-cycle pulse after 25th result accepted
// BEHAVIOUR
// - Reset: state=FILL, wr_cnt=0, row/col=0, anchor=12. Outputs: in_rdy=1, ram_wr=0, ram_rd=0,
//   ram_addr_wr=0, ram_addr_rd=12, pool_vld=0, pool_data=0, frame_done=0.
// - Reset mid-frame: abandons the frame; partial RAM contents are don't-care and are overwritten.
// - FILL: in_rdy=1; accept = in_vld&in_rdy. ram_wr=accept, ram_din=in_data, ram_addr_wr=wr_cnt.
//   - wr_cnt increments on accept only; gaps in in_vld stall it.
//   - Accept at wr_cnt=DIM*DIM-1 -> POOL, wr_cnt<=0.
// - POOL: in_rdy=0, ram_rd=1, ram_addr_rd=anchor.
//   - slot_free = !pool_vld | pool_rdy.
//   - On slot_free: pool_data<=max4(ram_dout), pool_vld<=1, advance window.
//   - Result latency = 1 cycle from anchor presentation.
//   - Advance: col<4 -> anchor+=2, col++.
//   - col==4 -> anchor+=14, col<=0, row++.
//   - Anchor sequence: 12,14,16,18,20,34,...,42,...,100,...,108.
//   - After 25th window is issued: -> DRAIN; ram_rd=0.
// - Backpressure: pool_vld=1 & pool_rdy=0 -> pool_data, anchor and counters held unchanged.
// - DRAIN: hold until the 25th result handshakes (pool_vld&pool_rdy).
//   - Then pool_vld<=0, frame_done<=1 for 1 cycle, state -> FILL, anchor<=12, row/col<=0.
//   - in_rdy reasserts in the same cycle frame_done is high.
// - Max: signed DW-bit compare. Ties pick any equal value (data identical). No saturation, no widening.
// - in_vld asserted outside FILL is ignored (not written, not counted).
// - ram_addr_rd holds the last anchor when ram_rd=0.
// STRUCTURE
// - Package l2_pkg:
//   - DIM, DW, AW; POOL_SIDE=5, N_WIN=25
//   - FIRST_ANCHOR=12, COL_STEP=2, ROW_STEP=14
//   - typedef enum {FILL,POOL,DRAIN} l2_state_t
//   - typedef logic signed [DW-1:0] l2_word_t
// - Sub-module pool_max4: combinational signed 4-input max (two-level compare tree); reused by later layers.
// - Top: FSM, wr_cnt, row/col/anchor counters, output register.
// TESTING
// - Ramp: in_data=0..120, pool_rdy=1 -> pool_data=12,14,16,18,20,34,...,108 (= anchor);
//   frame_done 1 cycle after 25th.
// - Signed: in_data=-addr -> pool_data=-(anchor-12): 0,-2,...,-8,-22,...,-96; never a positive value.
// - Backpressure: pool_rdy=0 for 5 cycles at window 7 -> pool_data=value 7 held stable;
//   no skipped or duplicated outputs; total = 25.
// - Input gaps: in_vld random 50% during FILL -> ram_addr_wr strictly sequential 0..120;
//   in_rdy=0 and no ram_wr throughout POOL/DRAIN.
// - Reset in POOL at window 10 -> next cycle pool_vld=0, in_rdy=1, ram_rd=0;
//   the following frame yields the correct 25 results.
// - Back-to-back frames, source always valid -> second frame's first write (addr 0)
//   in the frame_done cycle; both frames correct.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared constants and types for the layer-2 feature-map sequencer and its
// pooling datapath. Later layers reuse the word type and the max helper.
package l2_pkg;

    localparam int DIM       = 11;
    localparam int DW        = 18;
    localparam int AW        = 7;
    localparam int POOL_SIDE = 5;
    localparam int N_WIN     = 25;
    localparam int FRAME     = DIM * DIM;

    // Window anchor is the bottom-right word of each 2x2 window; the first
    // window's anchor sits one row and one column into the map.
    localparam logic [AW-1:0] FIRST_ANCHOR = 7'd12;
    localparam logic [AW-1:0] COL_STEP     = 7'd2;
    // Skipping from the last window of a pooled row to the first of the next
    // jumps two map rows back to column 1: 2*DIM - 2*(POOL_SIDE-1).
    localparam logic [AW-1:0] ROW_STEP     = 7'd14;
    localparam logic [AW-1:0] LAST_WR_ADDR = 7'(FRAME - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        POOL  = 2'd1,
        DRAIN = 2'd2
    } l2_state_t;

    typedef logic signed [DW-1:0] l2_word_t;

    // Signed two-input max; on a tie both operands are identical, so either
    // choice is correct.
    function automatic l2_word_t smax2(input l2_word_t a, input l2_word_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_max4.sv
// Combinational signed max of a 2x2 window, built as a two-level compare
// tree (row maxima first, then the max of the two rows).
module pool_max4
    import l2_pkg::*;
(
    input  l2_word_t tl,
    input  l2_word_t tr,
    input  l2_word_t bl,
    input  l2_word_t br,
    output l2_word_t max_out
);

    l2_word_t top_max;
    l2_word_t bot_max;

    assign top_max = smax2(tl, tr);
    assign bot_max = smax2(bl, br);
    assign max_out = smax2(top_max, bot_max);

endmodule

// File: rtl/l2_pool_ctrl.sv
// Layer-2 feature-map sequencer: fills the 11x11 RAM from the conv stage,
// then walks the 25 stride-2 2x2 windows and streams out their signed max.
// Row 10 and column 10 never fall inside a window (floor pooling).
module l2_pool_ctrl
    import l2_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [DW-1:0]   in_data,
    output logic            in_rdy,
    output logic            ram_wr,
    output logic [AW-1:0]   ram_addr_wr,
    output logic [DW-1:0]   ram_din,
    output logic            ram_rd,
    output logic [AW-1:0]   ram_addr_rd,
    input  logic [4*DW-1:0] ram_dout,
    output logic            pool_vld,
    output logic [DW-1:0]   pool_data,
    input  logic            pool_rdy,
    output logic            frame_done
);

    localparam logic [1:0] ST_FILL  = 2'(FILL);
    localparam logic [1:0] ST_POOL  = 2'(POOL);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

    localparam logic [2:0] LAST_IDX = 3'(POOL_SIDE - 1);

    logic [1:0]    state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] anchor;
    logic [2:0]    row;
    logic [2:0]    col;
    l2_word_t      pool_q;
    logic          vld_q;
    logic          done_q;

    logic          accept;
    logic          slot_free;
    logic          last_win;
    logic          out_hs;
    l2_word_t      win_tl;
    l2_word_t      win_tr;
    l2_word_t      win_bl;
    l2_word_t      win_br;
    l2_word_t      win_max;

    // Handshake and window-position decodes shared by the FSM and counters.
    assign accept    = in_vld && (state == ST_FILL);
    assign slot_free = !vld_q || pool_rdy;
    assign out_hs    = vld_q && pool_rdy;
    assign last_win  = (row == LAST_IDX) && (col == LAST_IDX);

    // Write port follows the conv stream directly; reads present the anchor.
    assign in_rdy      = (state == ST_FILL);
    assign ram_wr      = accept;
    assign ram_addr_wr = wr_cnt;
    assign ram_din     = in_data;
    assign ram_rd      = (state == ST_POOL);
    assign ram_addr_rd = anchor;
    assign pool_vld    = vld_q;
    assign pool_data   = pool_q;
    assign frame_done  = done_q;

    // Unpack the window words: [0]=TL, [1]=TR, [2]=BL, [3]=BR.
    assign win_tl = ram_dout[0*DW +: DW];
    assign win_tr = ram_dout[1*DW +: DW];
    assign win_bl = ram_dout[2*DW +: DW];
    assign win_br = ram_dout[3*DW +: DW];

    pool_max4 u_max4 (
        .tl      (win_tl),
        .tr      (win_tr),
        .bl      (win_bl),
        .br      (win_br),
        .max_out (win_max)
    );

    // Frame sequencing: FILL until the 121st pixel, POOL until the 25th
    // window is issued, DRAIN until that last result is taken downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            case (state)
                ST_FILL:  if (accept && (wr_cnt == LAST_WR_ADDR)) state <= ST_POOL;
                ST_POOL:  if (slot_free && last_win) state <= ST_DRAIN;
                ST_DRAIN: if (out_hs) state <= ST_FILL;
                default:  state <= ST_FILL;
            endcase
        end
    end

    // Write address counter; gaps in the conv stream simply stall it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (accept) begin
            if (wr_cnt == LAST_WR_ADDR) begin
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt + 7'd1;
            end
        end
    end

    // Window walker: steps the anchor along a pooled row, jumps to the next
    // pooled row after column 4, holds while the output slot is occupied,
    // and parks on the last anchor until the frame is drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            anchor <= FIRST_ANCHOR;
            row    <= '0;
            col    <= '0;
        end else if (state == ST_POOL) begin
            if (slot_free && !last_win) begin
                if (col == LAST_IDX) begin
                    anchor <= anchor + ROW_STEP;
                    col    <= '0;
                    row    <= row + 3'd1;
                end else begin
                    anchor <= anchor + COL_STEP;
                    col    <= col + 3'd1;
                end
            end
        end else if ((state == ST_DRAIN) && out_hs) begin
            anchor <= FIRST_ANCHOR;
            row    <= '0;
            col    <= '0;
        end
    end

    // Output register: captures a new max whenever the slot is free during
    // POOL, and retires the final result with a one-cycle frame_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pool_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_POOL: begin
                    if (slot_free) begin
                        pool_q <= win_max;
                        vld_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs) begin
                        vld_q  <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
